// File: rtl/cordic_iter_ctrl_pkg.sv
// Shared CORDIC definitions: default sizing and the 2-bit encoding of the
// iteration sequencer states.
package cordic_iter_ctrl_pkg;

  localparam int NITER_DEF = 16;
  localparam int CW_DEF    = 4;
  localparam int ITER_LAST = NITER_DEF - 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/cordic_iter_ctrl.sv
// Sequencer for one CORDIC rotation: request handshake, NITER enabled
// iterations of the external counter/datapath, then result handshake.
module cordic_iter_ctrl
  import cordic_iter_ctrl_pkg::*;
#(
  parameter int NITER = NITER_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          abort,
  input  logic [CW-1:0] iter_count,
  output logic          iter_start,
  output logic          iter_enable,
  output logic          dp_load,
  output logic          dp_en,
  output logic          iter_last,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          busy,
  output logic          seq_error
);

  localparam logic [CW-1:0] LAST_CNT = CW'(NITER - 1);

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [CW-1:0] shadow;
  logic          at_last;

  assign at_last = (shadow == LAST_CNT);

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (req_valid) state_nx = ST_LOAD;
      ST_LOAD: state_nx = abort ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        if (abort)        state_nx = ST_IDLE;
        else if (at_last) state_nx = ST_DONE;
      end
      ST_DONE: if (res_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Abort in LOAD/RUN clears the counter and withholds the micro-rotation.
  always_comb begin
    req_ready   = (state == ST_IDLE);
    busy        = (state == ST_LOAD) || (state == ST_RUN);
    dp_load     = (state == ST_LOAD);
    iter_enable = busy;
    iter_start  = (state == ST_LOAD) || (busy && abort);
    dp_en       = (state == ST_RUN) && !abort;
    iter_last   = (state == ST_RUN) && at_last && !abort;
    res_valid   = (state == ST_DONE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= ST_IDLE;
      shadow    <= '0;
      seq_error <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        ST_IDLE: if (req_valid) seq_error <= 1'b0;
        ST_LOAD: shadow <= '0;
        ST_RUN: begin
          // Compares the pre-edge count, so the wrap on the last edge is legal.
          if (iter_count != shadow) seq_error <= 1'b1;
          shadow <= shadow + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Self-checking bench: NITER=16 (counter wraps) and NITER=5 instances, each
// driving a behavioural stand-in for the iteration counter.
module tb_cordic_iter_ctrl;

  localparam int CW  = 4;
  localparam int NA  = 16;
  localparam int NB  = 5;

  typedef struct {
    int   lat;
    logic err;
  } sb_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // instance A (NITER = 2^CW)
  logic req_valid, req_ready, abort, iter_start, iter_enable, dp_load, dp_en;
  logic iter_last, res_valid, res_ready, busy, seq_error, fault_en;
  logic [CW-1:0] cnt, iter_count;

  // instance B (NITER = 5)
  logic req_valid_b, req_ready_b, iter_start_b, iter_enable_b, dp_load_b, dp_en_b;
  logic iter_last_b, res_valid_b, res_ready_b, busy_b, seq_error_b;
  logic [CW-1:0] cnt_b;

  assign iter_count = fault_en ? 4'd3 : cnt;

  cordic_iter_ctrl #(.NITER(NA), .CW(CW)) dut_a (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .abort(abort), .iter_count(iter_count), .iter_start(iter_start),
    .iter_enable(iter_enable), .dp_load(dp_load), .dp_en(dp_en),
    .iter_last(iter_last), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .seq_error(seq_error)
  );

  cordic_iter_ctrl #(.NITER(NB), .CW(CW)) dut_b (
    .clock(clock), .reset(reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .abort(1'b0), .iter_count(cnt_b), .iter_start(iter_start_b),
    .iter_enable(iter_enable_b), .dp_load(dp_load_b), .dp_en(dp_en_b),
    .iter_last(iter_last_b), .res_valid(res_valid_b), .res_ready(res_ready_b),
    .busy(busy_b), .seq_error(seq_error_b)
  );

  // Stand-in iteration counters: clear on start, count on enable.
  always @(posedge clock) begin
    if (!reset) cnt <= '0;
    else if (iter_enable) cnt <= iter_start ? '0 : cnt + 4'd1;
  end

  always @(posedge clock) begin
    if (!reset) cnt_b <= '0;
    else if (iter_enable_b) cnt_b <= iter_start_b ? '0 : cnt_b + 4'd1;
  end

  int  n_vec = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  acc_cyc = 0;
  sb_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic accept(input logic exp_err);
    exp_q.push_back('{NA + 1, exp_err});
    check("req_ready_pre", req_ready, 1'b1);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    acc_cyc = cyc;
    check("load_ctrl", {dp_load, iter_start, iter_enable, busy, req_ready, dp_en}, 6'b111100);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!res_valid && n < budget) begin
      step();
      n++;
    end
    check("res_valid_timeout", res_valid, 1'b1);
  endtask

  task automatic check_result(input logic err_obs);
    sb_t e;
    if (exp_q.size() == 0) begin
      check("sb_underflow", exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      check("latency", cyc - acc_cyc, e.lat);
      check("res_seq_error", err_obs, e.err);
    end
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; abort = 1'b0; res_ready = 1'b0; fault_en = 1'b0;
    req_valid_b = 1'b0; res_ready_b = 1'b0;
    step(); step();
    reset = 1'b1;
    check("reset_outs",
          {req_ready, busy, dp_load, dp_en, iter_start, iter_enable, iter_last, res_valid, seq_error},
          9'b1_0000_0000);
    check("reset_outs_b",
          {req_ready_b, busy_b, dp_load_b, dp_en_b, iter_start_b, iter_enable_b, iter_last_b,
           res_valid_b, seq_error_b}, 9'b1_0000_0000);

    // Basic operation with per-iteration checks
    res_ready = 1'b1;
    accept(1'b0);
    for (int k = 0; k < NA; k++) begin
      step();
      check("run_ctrl", {dp_en, iter_enable, iter_start, busy, res_valid}, 5'b11010);
      check("run_count", iter_count, k);
      check("iter_last", iter_last, (k == NA - 1));
    end
    step();
    check("res_valid_basic", res_valid, 1'b1);
    check_result(seq_error);
    step();
    check("res_drop", {res_valid, req_ready}, 2'b01);

    // Result backpressure: everything holds while res_ready is low
    res_ready = 1'b0;
    accept(1'b0);
    wait_done(40);
    check_result(seq_error);
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_hold", {res_valid, dp_en, iter_enable, req_ready, busy}, 5'b10000);
      check("bp_count", iter_count, 4'(NA));
    end
    res_ready = 1'b1;
    step();
    check("bp_release", {res_valid, req_ready}, 2'b01);

    // Abort at count 7
    accept(1'b0);
    exp_q.pop_back();
    repeat (8) step();
    check("abort_count", iter_count, 4'd7);
    abort = 1'b1;
    #1;
    check("abort_ctrl", {iter_start, iter_enable, dp_en}, 3'b110);
    step();
    abort = 1'b0;
    check("abort_idle", {req_ready, busy, res_valid}, 3'b100);
    check("abort_cleared", iter_count, 4'd0);
    for (int k = 0; k < 20; k++) begin
      step();
      check("abort_no_res", res_valid, 1'b0);
    end

    // Synchronous reset mid-RUN at count 10, then a full operation
    accept(1'b0);
    exp_q.pop_back();
    repeat (11) step();
    check("rst_count", iter_count, 4'd10);
    reset = 1'b0;
    step();
    check("rst_mid_outs",
          {req_ready, busy, dp_load, dp_en, iter_start, iter_enable, iter_last, res_valid, seq_error},
          9'b1_0000_0000);
    reset = 1'b1;
    accept(1'b0);
    wait_done(40);
    check_result(seq_error);
    step();
    check("rst_op_done", req_ready, 1'b1);

    // Counter fault at shadow 4
    res_ready = 1'b0;
    accept(1'b1);
    repeat (5) step();
    check("fault_pre", {seq_error, cnt}, {1'b0, 4'd4});
    fault_en = 1'b1;
    step();
    fault_en = 1'b0;
    check("fault_set", seq_error, 1'b1);
    wait_done(40);
    check_result(seq_error);
    step();
    check("fault_sticky_done", {seq_error, res_valid}, 2'b11);

    // req_valid with res_ready in DONE: completion first, accept next cycle
    req_valid = 1'b1;
    res_ready = 1'b1;
    step();
    check("sim_idle", {req_ready, busy, res_valid, seq_error}, 4'b1001);
    exp_q.push_back('{NA + 1, 1'b0});
    step();
    req_valid = 1'b0;
    acc_cyc = cyc;
    check("sim_accept", {dp_load, seq_error}, 2'b10);
    wait_done(40);
    check_result(seq_error);
    step();
    check("sim_done", res_valid, 1'b0);

    // NITER = 5 instance
    res_ready_b = 1'b1;
    check("b_ready", req_ready_b, 1'b1);
    req_valid_b = 1'b1;
    step();
    req_valid_b = 1'b0;
    acc_cyc = cyc;
    exp_q.push_back('{NB + 1, 1'b0});
    for (int k = 0; k < NB; k++) begin
      step();
      check("b_count", cnt_b, k);
      check("b_iter_last", iter_last_b, (k == NB - 1));
    end
    step();
    check("b_res_valid", res_valid_b, 1'b1);
    check_result(seq_error_b);
    step();
    check("b_idle", {res_valid_b, req_ready_b}, 2'b01);

    check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
